// File: rtl/sinc_seq_pkg.sv
// Shared types and Q2.22 saturation helper for the sinc coefficient sequencer.
package sinc_seq_pkg;

  localparam int Q_W      = 24;
  localparam int SAT_IN_W = 48;

  localparam logic [Q_W-1:0] Q22_MAX = 24'h7FFFFF;
  localparam logic [Q_W-1:0] Q22_MIN = 24'h800000;

  localparam logic signed [SAT_IN_W-1:0] SAT_HI = 48'sh0000_007F_FFFF;
  localparam logic signed [SAT_IN_W-1:0] SAT_LO = -48'sh0000_0080_0000;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    HOLD,
    EMIT_FWD,
    MIRROR
  } state_e;

  typedef struct packed {
    logic [Q_W-1:0] value;
    logic           clamped;
  } sat_result_t;

  function automatic sat_result_t sat_q22(input logic signed [SAT_IN_W-1:0] x);
    sat_result_t r;
    if (x > SAT_HI) begin
      r.value   = Q22_MAX;
      r.clamped = 1'b1;
    end else if (x < SAT_LO) begin
      r.value   = Q22_MIN;
      r.clamped = 1'b1;
    end else begin
      r.value   = x[Q_W-1:0];
      r.clamped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sinc_coeff_half_buf.sv
// Half-tap store: one write port, one combinational read port, no reset on contents.
module sinc_coeff_half_buf #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 3,
  parameter int AW    = 2
) (
  input  logic             i_clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] rows [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
      logic [WIDTH-1:0] row_reg;

      always_ff @(posedge i_clk) begin
        if (wr_en && (wr_addr == AW'(gi))) begin
          row_reg <= wr_data;
        end
      end

      assign rows[gi] = row_reg;
    end
  endgenerate

  // Explicit compare mux keeps out-of-range addresses well defined for non power-of-two depths.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_data = rows[i];
      end
    end
  end

endmodule

// File: rtl/sinc_coeff_sequencer.sv
// Drives theta into a sinc unit, captures taps 0..CENTER and streams the full
// symmetric tap set, replaying the upper half mirrored from a local buffer.
module sinc_coeff_sequencer
  import sinc_seq_pkg::*;
#(
  parameter int IN_WIDTH = Q_W,
  parameter int K        = 8,
  parameter int N_TAPS   = 63,
  localparam int IDX_W   = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [IN_WIDTH-1:0] i_step,
  output logic [IN_WIDTH-1:0] o_theta,
  input  logic [IN_WIDTH-1:0] i_sinc,
  output logic [IN_WIDTH-1:0] o_coeff,
  output logic [IDX_W-1:0]    o_coeff_idx,
  output logic                o_coeff_last,
  output logic                o_coeff_valid,
  input  logic                i_coeff_ready,
  output logic                o_busy,
  output logic                o_range_err
);

  localparam int CENTER   = N_TAPS / 2;
  localparam int HOLD_CYC = 2 * K + 3;
  localparam int ACC_W    = IN_WIDTH + IDX_W + 1;
  localparam int BUF_D    = CENTER + 1;
  localparam int BUF_AW   = (BUF_D > 1) ? $clog2(BUF_D) : 1;
  localparam int HC_W     = $clog2(HOLD_CYC + 1);

  localparam logic signed [ACC_W-1:0] CENTER_S = ACC_W'(CENTER);

  generate
    if ((N_TAPS % 2) == 0) begin : g_bad_taps
      $error("sinc_coeff_sequencer: N_TAPS must be odd");
    end
    if (IN_WIDTH != Q_W) begin : g_bad_width
      $error("sinc_coeff_sequencer: IN_WIDTH must match the Q2.22 word width");
    end
  endgenerate

  state_e                    state_reg;
  logic [IN_WIDTH-1:0]       step_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  logic [HC_W-1:0]           hold_cnt_reg;
  logic [IDX_W-1:0]          idx_reg;
  logic [IN_WIDTH-1:0]       theta_reg;
  logic [IN_WIDTH-1:0]       coeff_reg;
  logic [IDX_W-1:0]          coeff_idx_reg;
  logic                      coeff_last_reg;
  logic                      coeff_valid_reg;
  logic                      range_err_reg;

  logic signed [ACC_W-1:0]   step_ext;
  logic signed [ACC_W-1:0]   prime_acc;
  logic signed [ACC_W-1:0]   next_acc;
  sat_result_t               sat_prime;
  sat_result_t               sat_next;
  logic                      fire;
  logic                      last_hold;
  logic [IDX_W-1:0]          idx_inc;
  logic [IDX_W-1:0]          rd_idx;
  logic                      buf_wr_en;
  logic [IN_WIDTH-1:0]       buf_rd_data;

  assign step_ext  = ACC_W'($signed(step_reg));
  assign prime_acc = -(CENTER_S * step_ext);
  assign next_acc  = acc_reg + step_ext;
  assign sat_prime = sat_q22(SAT_IN_W'(prime_acc));
  assign sat_next  = sat_q22(SAT_IN_W'(next_acc));

  assign fire      = coeff_valid_reg && i_coeff_ready;
  assign last_hold = (hold_cnt_reg == HC_W'(HOLD_CYC - 1));
  assign idx_inc   = idx_reg + IDX_W'(1);
  // Source slot for the tap following idx: buf[N_TAPS-1-(idx+1)].
  assign rd_idx    = IDX_W'(N_TAPS - 2) - idx_reg;
  assign buf_wr_en = (state_reg == HOLD) && last_hold;

  sinc_coeff_half_buf #(
    .WIDTH (IN_WIDTH),
    .DEPTH (BUF_D),
    .AW    (BUF_AW)
  ) u_half_buf (
    .i_clk   (i_clk),
    .wr_en   (buf_wr_en),
    .wr_addr (BUF_AW'(idx_reg)),
    .wr_data (i_sinc),
    .rd_addr (BUF_AW'(rd_idx)),
    .rd_data (buf_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg       <= IDLE;
      step_reg        <= '0;
      acc_reg         <= '0;
      hold_cnt_reg    <= '0;
      idx_reg         <= '0;
      theta_reg       <= '0;
      coeff_reg       <= '0;
      coeff_idx_reg   <= '0;
      coeff_last_reg  <= 1'b0;
      coeff_valid_reg <= 1'b0;
      range_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            step_reg      <= i_step;
            range_err_reg <= 1'b0;
            state_reg     <= PRIME;
          end
        end

        PRIME: begin
          acc_reg      <= prime_acc;
          theta_reg    <= sat_prime.value;
          hold_cnt_reg <= '0;
          idx_reg      <= '0;
          if (sat_prime.clamped) begin
            range_err_reg <= 1'b1;
          end
          state_reg    <= HOLD;
        end

        // Theta has been stable long enough for a full sinc frame plus pipeline.
        HOLD: begin
          if (last_hold) begin
            coeff_reg       <= i_sinc;
            coeff_idx_reg   <= idx_reg;
            coeff_last_reg  <= (idx_reg == IDX_W'(N_TAPS - 1));
            coeff_valid_reg <= 1'b1;
            state_reg       <= EMIT_FWD;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HC_W'(1);
          end
        end

        EMIT_FWD: begin
          if (fire) begin
            if (idx_reg == IDX_W'(CENTER)) begin
              if (N_TAPS == 1) begin
                coeff_valid_reg <= 1'b0;
                coeff_last_reg  <= 1'b0;
                state_reg       <= IDLE;
              end else begin
                idx_reg        <= idx_inc;
                coeff_reg      <= buf_rd_data;
                coeff_idx_reg  <= idx_inc;
                coeff_last_reg <= (idx_inc == IDX_W'(N_TAPS - 1));
                state_reg      <= MIRROR;
              end
            end else begin
              idx_reg         <= idx_inc;
              acc_reg         <= next_acc;
              theta_reg       <= sat_next.value;
              if (sat_next.clamped) begin
                range_err_reg <= 1'b1;
              end
              coeff_valid_reg <= 1'b0;
              hold_cnt_reg    <= '0;
              state_reg       <= HOLD;
            end
          end
        end

        MIRROR: begin
          if (fire) begin
            if (coeff_last_reg) begin
              coeff_valid_reg <= 1'b0;
              coeff_last_reg  <= 1'b0;
              state_reg       <= IDLE;
            end else begin
              idx_reg        <= idx_inc;
              coeff_reg      <= buf_rd_data;
              coeff_idx_reg  <= idx_inc;
              coeff_last_reg <= (idx_inc == IDX_W'(N_TAPS - 1));
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_theta       = theta_reg;
  assign o_coeff       = coeff_reg;
  assign o_coeff_idx   = coeff_idx_reg;
  assign o_coeff_last  = coeff_last_reg;
  assign o_coeff_valid = coeff_valid_reg;
  assign o_busy        = (state_reg != IDLE);
  assign o_range_err   = range_err_reg;

endmodule

// File: tb/tb_sinc_coeff_sequencer.sv
// Bench for sinc_coeff_sequencer: behavioural sinc unit, tap scoreboard, table-driven tap sets
// and hand-written reset / restart / clamp sequences.
module tb_sinc_coeff_sequencer;

  localparam int KB   = 8;
  localparam int NT   = 5;
  localparam int C    = NT / 2;
  localparam int HOLD = 2 * KB + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 5-tap instance
  logic        rst, start, ready;
  logic [23:0] step, sinc5, theta5, coeff;
  logic [2:0]  cidx;
  logic        last, valid, busy, err;

  // 63-tap instance, used only for the saturation case
  logic        rst63, start63;
  logic [23:0] step63, theta63, coeff63, sinc63;
  logic [5:0]  idx63;
  logic        last63, valid63, busy63, err63, ready63;

  int n_vec = 0;
  int n_bad = 0;
  int ready_pct = 100;

  typedef struct {
    int          idx;
    logic [23:0] coeff;
    logic        last;
    logic [23:0] theta;
    logic        fwd;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [23:0] step;
    int          ready_pct;
    logic [23:0] exp_theta0;
    logic        exp_err;
  } vec_t;
  vec_t tbl[7];

  sinc_coeff_sequencer #(.IN_WIDTH(24), .K(KB), .N_TAPS(NT)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_step        (step),
    .o_theta       (theta5),
    .i_sinc        (sinc5),
    .o_coeff       (coeff),
    .o_coeff_idx   (cidx),
    .o_coeff_last  (last),
    .o_coeff_valid (valid),
    .i_coeff_ready (ready),
    .o_busy        (busy),
    .o_range_err   (err)
  );

  sinc_coeff_sequencer #(.IN_WIDTH(24), .K(KB), .N_TAPS(63)) dut63 (
    .i_clk         (clk),
    .i_rst         (rst63),
    .i_start       (start63),
    .i_step        (step63),
    .o_theta       (theta63),
    .i_sinc        (sinc63),
    .o_coeff       (coeff63),
    .o_coeff_idx   (idx63),
    .o_coeff_last  (last63),
    .o_coeff_valid (valid63),
    .i_coeff_ready (ready63),
    .o_busy        (busy63),
    .o_range_err   (err63)
  );

  function automatic logic [23:0] sat_theta(input longint v);
    logic [63:0] t;
    if (v > 64'sd8388607)       t = 64'h7FFFFF;
    else if (v < -64'sd8388608) t = 64'hFFFF_FFFF_FF80_0000;
    else                        t = v;
    return t[23:0];
  endfunction

  // sinc(x) = sin(x)/x, x taken as a Q2.22 value, result rounded to Q2.22
  function automatic logic [23:0] q22_sinc(input logic [23:0] th);
    int          ti;
    real         x, s, v;
    int          r;
    logic [31:0] rb;
    ti = int'($signed(th));
    x  = real'(ti) / 4194304.0;
    s  = (x == 0.0) ? 1.0 : $sin(x) / x;
    v  = s * 4194304.0;
    r  = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    rb = r;
    return rb[23:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic push_expected(input logic [23:0] s);
    exp_t   e;
    int     j;
    longint a;
    for (int i = 0; i < NT; i++) begin
      j       = (i <= C) ? i : NT - 1 - i;
      a       = longint'(j - C) * longint'($signed(s));
      e.idx   = i;
      e.theta = sat_theta(a);
      e.coeff = q22_sinc(e.theta);
      e.last  = (i == NT - 1);
      e.fwd   = (i <= C);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_pulse(input logic [23:0] s);
    @(posedge clk); #1;
    start = 1'b1;
    step  = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) fail_now(name);
  endtask

  task automatic run_set(input logic [23:0] s, input int pct, input logic [23:0] th0, input logic err0);
    int cyc;
    bit got;
    ready_pct = pct;
    push_expected(s);
    start_pulse(s);
    cyc = 1;
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared_on_start", 32'(err), 32'd0);
    got = 0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(posedge clk); #1;
      cyc++;
      @(negedge clk);
      if (cyc == 2) begin
        check("first_theta", 32'(theta5), 32'(th0));
        check("range_err", 32'(err), 32'(err0));
      end
      if (valid) got = 1;
    end
    if (!got) fail_now("first_valid");
    else check("first_valid_cycle", 32'(cyc), 32'(HOLD + 2));
    wait_idle("set_complete");
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("range_err_end", 32'(err), 32'(err0));
  endtask

  // Behavioural sinc unit: registered result refreshed once per K-cycle frame.
  initial begin
    int fcnt = 0;
    sinc5 = '0;
    forever begin
      @(posedge clk);
      if (fcnt == KB - 1) begin
        sinc5 <= q22_sinc(theta5);
        fcnt = 0;
      end else begin
        fcnt++;
      end
    end
  end

  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ready = (int'($urandom_range(0, 99)) < ready_pct);
    end
  end

  // Scoreboard / stall monitor, sampled on the falling edge.
  initial begin
    logic        stall_prev = 1'b0;
    logic [23:0] s_coeff = '0;
    logic [2:0]  s_idx = '0;
    logic        s_last = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (valid && !rst) begin
        if (stall_prev) begin
          check("stall_coeff", 32'(coeff), 32'(s_coeff));
          check("stall_idx", 32'(cidx), 32'(s_idx));
          check("stall_last", 32'(last), 32'(s_last));
        end
        if (ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL extra_tap: got idx %0d coeff 0x%0h, want none", cidx, coeff);
          end else begin
            e = exp_q.pop_front();
            $display("tap idx=%0d coeff=0x%06h last=%0b theta=0x%06h", cidx, coeff, last, theta5);
            check("tap_idx", 32'(cidx), 32'(e.idx));
            check("tap_coeff", 32'(coeff), 32'(e.coeff));
            check("tap_last", 32'(last), 32'(e.last));
            if (e.fwd) check("tap_theta", 32'(theta5), 32'(e.theta));
          end
        end
      end
      stall_prev = valid && !ready;
      s_coeff    = coeff;
      s_idx      = cidx;
      s_last     = last;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    tbl[0] = '{24'h200000, 100, 24'hC00000, 1'b0};
    tbl[1] = '{24'h200000,  50, 24'hC00000, 1'b0};
    tbl[2] = '{24'h000000, 100, 24'h000000, 1'b0};
    tbl[3] = '{24'h400000,  60, 24'h800000, 1'b0};
    tbl[4] = '{24'h7FFFFF, 100, 24'h800000, 1'b1};
    tbl[5] = '{24'hE00000,  70, 24'h400000, 1'b0};
    tbl[6] = '{24'h100000,  30, 24'hE00000, 1'b0};

    rst = 1'b1; start = 1'b0; step = '0;
    rst63 = 1'b1; start63 = 1'b0; step63 = '0; sinc63 = '0; ready63 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rst63 = 1'b0;

    @(negedge clk);
    check("rst_theta", 32'(theta5), 32'd0);
    check("rst_coeff", 32'(coeff), 32'd0);
    check("rst_idx", 32'(cidx), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    for (int v = 0; v < 7; v++) begin
      run_set(tbl[v].step, tbl[v].ready_pct, tbl[v].exp_theta0, tbl[v].exp_err);
    end

    // Reset during the HOLD of tap 1, then a clean set.
    ready_pct = 100;
    push_expected(24'h200000);
    start_pulse(24'h200000);
    hit = 0;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(posedge clk);
      if (exp_q.size() == NT - 1) hit = 1;
    end
    if (!hit) fail_now("tap0_handshake");
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("hold1_busy", 32'(busy), 32'd1);
    check("hold1_valid", 32'(valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_theta", 32'(theta5), 32'd0);
    check("midrst_idx", 32'(cidx), 32'd0);
    exp_q.delete();
    run_set(24'h200000, 100, 24'hC00000, 1'b0);

    // Start pulse during MIRROR is ignored; a later start is accepted.
    ready_pct = 100;
    push_expected(24'h100000);
    start_pulse(24'h100000);
    hit = 0;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      if (valid && (int'(cidx) > C)) hit = 1;
    end
    if (!hit) fail_now("reach_mirror");
    @(posedge clk); #1;
    start = 1'b1;
    step  = 24'h7FFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("mirror_start_ignored_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("mirror_start_still_idle", 32'(busy), 32'd0);
    check("mirror_start_err", 32'(err), 32'd0);
    check("mirror_queue_drained", 32'(exp_q.size()), 32'd0);
    run_set(24'h200000, 50, 24'hC00000, 1'b0);

    // 63-tap clamp: -31 * 0x7FFFFF saturates to -2.0.
    @(negedge clk);
    check("t63_rst_busy", 32'(busy63), 32'd0);
    check("t63_rst_err", 32'(err63), 32'd0);
    @(posedge clk); #1;
    start63 = 1'b1;
    step63  = 24'h7FFFFF;
    @(posedge clk); #1;
    start63 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t63_theta_clamped", 32'(theta63), 32'h800000);
    check("t63_range_err", 32'(err63), 32'd1);
    @(posedge clk); #1;
    rst63 = 1'b1;
    @(posedge clk); #1;
    rst63 = 1'b0;
    @(negedge clk);
    check("t63_rst_clears_err", 32'(err63), 32'd0);
    check("t63_rst_clears_theta", 32'(theta63), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
